// File: rtl/emissor_teclado_pkg.sv
// Shared definitions for the key emitter: FSM state encoding, key count and BCD validity helper.
package emissor_teclado_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        PRESSIONA = 2'd1,
        SOLTA     = 2'd2
    } estado_t;

    localparam int unsigned NUM_TECLAS = 10;

    function automatic logic bcd_valido(input logic [3:0] bcd);
        return bcd <= 4'd9;
    endfunction

endpackage

// File: rtl/emissor_teclado_decodificador.sv
// Combinational BCD to one-hot key decoder; codes above 9 decode to all zeros.
module decodificador_bcd_onehot
    import emissor_teclado_pkg::*;
(
    input  logic [3:0]            i_bcd,
    output logic [NUM_TECLAS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (bcd_valido(i_bcd)) begin
            o_onehot = NUM_TECLAS'(1) << i_bcd;
        end
    end

endmodule

// File: rtl/emissor_teclado.sv
// Emits one BCD digit as a timed press/release on one-hot key lines.
// Optional one-entry holding buffer enabled by defining EMISSOR_TECLADO_FILA_EN.
module emissor_teclado
    import emissor_teclado_pkg::*;
#(
    parameter int unsigned TEMPO_PRESSIONADO = 4,
    parameter int unsigned TEMPO_SOLTO       = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enablen,
    input  logic [3:0]            BCD,
    input  logic                  dado_valido,
    output logic                  pronto,
    output logic [NUM_TECLAS-1:0] teclado,
    output logic                  concluido,
    output logic                  erro
);

    localparam logic [7:0] CARGA_PRESS = 8'(TEMPO_PRESSIONADO - 1);
    localparam logic [7:0] CARGA_SOLTO = 8'(TEMPO_SOLTO - 1);

    estado_t               r_estado;
    estado_t               w_prox_estado;
    logic [7:0]            r_contador;
    logic [7:0]            w_contador_d;
    logic [3:0]            r_digito;
    logic [3:0]            w_digito_d;
    logic [NUM_TECLAS-1:0] r_teclado;
    logic [NUM_TECLAS-1:0] w_onehot;
    logic                  r_erro;
    logic                  w_aceita;
    logic                  w_bcd_ok;
    logic                  w_fim_contagem;

`ifdef EMISSOR_TECLADO_FILA_EN
    logic                  r_buf_valido;
    logic [3:0]            r_buf_digito;
    logic                  w_bufferiza;
    logic                  w_consome_buf;
`endif

    assign w_aceita       = dado_valido & pronto;
    assign w_bcd_ok       = bcd_valido(BCD);
    assign w_fim_contagem = (r_contador == 8'd0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next-state, counter and digit selection
    always_comb begin
        w_prox_estado = r_estado;
        w_contador_d  = r_contador;
        w_digito_d    = r_digito;
        unique case (r_estado)
            OCIOSO: begin
                if (w_aceita && w_bcd_ok) begin
                    w_prox_estado = PRESSIONA;
                    w_contador_d  = CARGA_PRESS;
                    w_digito_d    = BCD;
                end
            end
            PRESSIONA: begin
                if (w_fim_contagem) begin
                    w_prox_estado = SOLTA;
                    w_contador_d  = CARGA_SOLTO;
                end else begin
                    w_contador_d = r_contador - 8'd1;
                end
            end
            SOLTA: begin
                if (w_fim_contagem) begin
                    w_prox_estado = OCIOSO;
`ifdef EMISSOR_TECLADO_FILA_EN
                    // A waiting digit chains straight into the next press, no idle cycle.
                    if (r_buf_valido) begin
                        w_prox_estado = PRESSIONA;
                        w_contador_d  = CARGA_PRESS;
                        w_digito_d    = r_buf_digito;
                    end else if (w_aceita && w_bcd_ok) begin
                        w_prox_estado = PRESSIONA;
                        w_contador_d  = CARGA_PRESS;
                        w_digito_d    = BCD;
                    end
`endif
                end else begin
                    w_contador_d = r_contador - 8'd1;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
                w_contador_d  = 8'd0;
            end
        endcase
    end

    // Outputs
    always_comb begin
`ifdef EMISSOR_TECLADO_FILA_EN
        pronto = ~enablen & ~r_buf_valido;
`else
        pronto = ~enablen & (r_estado == OCIOSO);
`endif
        concluido = (r_estado == SOLTA) && w_fim_contagem;
        teclado   = r_teclado;
        erro      = r_erro;
    end

    decodificador_bcd_onehot u_decodificador (
        .i_bcd    (w_digito_d),
        .o_onehot (w_onehot)
    );

    // Key lines are registered from the next state so they never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_contador <= 8'd0;
            r_digito   <= 4'd0;
            r_teclado  <= '0;
            r_erro     <= 1'b0;
        end else begin
            r_contador <= w_contador_d;
            r_digito   <= w_digito_d;
            r_teclado  <= (w_prox_estado == PRESSIONA) ? w_onehot : '0;
            r_erro     <= w_aceita & ~w_bcd_ok;
        end
    end

`ifdef EMISSOR_TECLADO_FILA_EN
    assign w_bufferiza   = w_aceita & w_bcd_ok &
                           ((r_estado == PRESSIONA) | ((r_estado == SOLTA) & ~w_fim_contagem));
    assign w_consome_buf = (r_estado == SOLTA) & w_fim_contagem & r_buf_valido;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_valido <= 1'b0;
            r_buf_digito <= 4'd0;
        end else if (w_bufferiza) begin
            r_buf_valido <= 1'b1;
            r_buf_digito <= BCD;
        end else if (w_consome_buf) begin
            r_buf_valido <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/emissor_teclado.md
EMISSOR_TECLADO -- requirements
Module: emissor_teclado

Interface
REQ-001 Parameter TEMPO_PRESSIONADO, default 4: cycles a key stays asserted on teclado (legal range 1..255).
REQ-002 Parameter TEMPO_SOLTO, default 2: cycles of all-zero teclado after each release (legal range 1..255).
REQ-003 Port clock  input  1: single clock; all logic rising-edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port enablen  input  1: active-low enable; when high, no new digit is accepted.
REQ-006 Port BCD  input  4: digit to emit.
REQ-007 Port dado_valido  input  1: request strobe; BCD is sampled when dado_valido=1 and pronto=1 on the same edge.
REQ-008 Port pronto  output  1: block can accept a digit this cycle.
REQ-009 Port teclado  output  10: one-hot key lines; digit d drives teclado[d]=1.
REQ-010 Port concluido  output  1: one-cycle pulse when a key's TEMPO_SOLTO gap ends.
REQ-011 Port erro  output  1: one-cycle pulse when an accepted BCD is >9.

Function
REQ-012 The block SHALL implement FSM states OCIOSO, PRESSIONA, SOLTA.
REQ-013 OCIOSO: teclado=0; pronto=~enablen; accepting a digit 0..9 -> PRESSIONA on the next edge with the counter loaded to TEMPO_PRESSIONADO-1.
REQ-014 Accepting BCD 10..15 SHALL pulse erro for one cycle on the next edge, leave teclado=0, and remain in OCIOSO.
REQ-015 PRESSIONA: teclado=one-hot(latched digit) for exactly TEMPO_PRESSIONADO cycles, then -> SOLTA with the counter loaded to TEMPO_SOLTO-1.
REQ-016 SOLTA: teclado=0 for exactly TEMPO_SOLTO cycles; concluido=1 in the last SOLTA cycle; then -> OCIOSO, or directly -> PRESSIONA if a buffered digit exists (REQ-024).
REQ-017 Latency: the first cycle with teclado≠0 SHALL be the cycle after acceptance.
REQ-018 teclado SHALL never have more than one bit set and SHALL be registered (glitch-free).
REQ-019 BCD and dado_valido SHALL be ignored while pronto=0; the latched digit SHALL not change mid-press.
REQ-020 enablen rising during PRESSIONA or SOLTA SHALL NOT abort the sequence; it only blocks new acceptances.
REQ-021 The counter SHALL be 8 bits wide and count down; no wrap-around occurs within legal parameter ranges.

Reset
REQ-022 On reset: state=OCIOSO, teclado=0, concluido=0, erro=0, counter=0, buffer empty; pronto=~enablen from the first cycle after reset.
REQ-023 Reset asserted mid-PRESSIONA SHALL clear teclado on the same edge, with no concluido pulse.

Configuration
REQ-024 With EMISSOR_TECLADO_FILA_EN defined: one-entry holding buffer; pronto=~enablen & buffer_empty in any state; a digit accepted during PRESSIONA/SOLTA is emitted directly after SOLTA without an idle cycle; an invalid digit pulses erro at acceptance and is not buffered.
REQ-025 Without EMISSOR_TECLADO_FILA_EN: no buffer; pronto=0 outside OCIOSO.

Structure
REQ-026 A shared package emissor_teclado_pkg SHALL hold the state encoding (OCIOSO=2'd0, PRESSIONA=2'd1, SOLTA=2'd2) and the constant NUM_TECLAS=10.
REQ-027 One sub-module, decodificador_bcd_onehot (combinational, 4-bit to 10-bit one-hot, all-zero for >9), SHALL be instantiated; FSM and counters SHALL remain in emissor_teclado.

Verification
REQ-028 Defaults, enablen=0, BCD=7 strobed once -> teclado=10'b0010000000 for cycles 1-4 after acceptance, 0 for cycles 5-6, concluido in cycle 6, pronto=1 in cycle 7.
REQ-029 Sweep BCD 0..9, one digit per completed sequence -> exactly one teclado bit per press, at the index equal to BCD.
REQ-030 BCD=12 strobed -> erro pulses for one cycle, teclado stays 0, pronto stays 1.
REQ-031 enablen=1 with BCD=3 strobed -> nothing accepted; enablen raised during a press of 5 -> the press and gap still complete.
REQ-032 Reset asserted in the 2nd PRESSIONA cycle -> teclado=0 on the next edge, no concluido pulse, state=OCIOSO.
REQ-033 FILA_EN build: strobe 1, then 2 during the press of 1 -> key 1 held 4 cycles, 2 cycles idle, key 2 held 4 cycles immediately after, two concluido pulses.
